// File: rtl/otter_pkg.sv
// Shared fetch-unit types: fetch FSM encoding, {IR, PC} FIFO entry and the
// default boot address.
package otter_pkg;

  // Default first fetch address after reset.
  localparam logic [31:0] OTTER_RESET_VEC = 32'h0000_0000;

  // Fixed encodings kept as plain constants so older code can keep using them.
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    FS_BOOT  = ST_BOOT,
    FS_RUN   = ST_RUN,
    FS_FAULT = ST_FAULT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/otter_fetch_fifo.sv
// Two-entry {IR, PC} buffer between instruction memory and decode.
// Clear has priority over push/pop; a push into a full buffer is accepted
// only when the head is popped in the same cycle.
module otter_fetch_fifo
  import otter_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   occupancy,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  fetch_entry_t mem_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         full;
  logic         do_push, do_pop;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign occupancy = count_q;
  assign head      = mem_q[rd_ptr_q];

  // Next pointers, count and storage from push/pop/clear requests.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_push  = push && (!full || pop);
    do_pop   = pop && !empty;
    if (clr) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction fetch unit: BOOT/RUN/FAULT sequencer, one-cycle
// instruction memory interface and a 2-entry output buffer toward decode.
// Optional performance counters are built when OTTER_FETCH_PERF_EN is
// defined; otherwise the counter ports read as zero.
module otter_fetch_unit #(
  parameter logic [31:0] RESET_VEC = otter_pkg::OTTER_RESET_VEC
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_IR,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_NEXT_PC,
  output logic        IF_FAULT,
  output logic [31:0] PERF_FETCH_CNT,
  output logic [31:0] PERF_STALL_CNT
);
  import otter_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;

  logic         redir, redir_ok, redir_bad;
  logic         if_valid, pop, push, req;
  logic [31:0]  req_addr, if_pc;
  logic [2:0]   credit_need;
  logic [1:0]   fifo_occ;
  logic         fifo_empty;
  fetch_entry_t fifo_head, push_entry;

  otter_fetch_fifo u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .clr       (redir),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .occupancy (fifo_occ),
    .empty     (fifo_empty)
  );

  // Redirect decode, pop/push, request issue with buffer credit, next state.
  always_comb begin
    // Redirects are ignored during the single BOOT cycle.
    redir     = REDIRECT && (state_q != FS_BOOT);
    redir_ok  = redir && (REDIRECT_PC[1:0] == 2'b00);
    redir_bad = redir && !redir_ok;
    if_valid  = RST_N && !fifo_empty && (state_q != FS_FAULT);
    pop       = if_valid && !STALL && !redir;
    // A response returning while a redirect is taken belongs to the old path.
    push      = inflight_q && !redir;
    // Slots that will be spoken for after this cycle's pop.
    credit_need = {1'b0, fifo_occ} + {2'b00, inflight_q} - {2'b00, pop};
    req      = 1'b0;
    req_addr = fetch_pc_q;
    if (RST_N) begin
      if (redir_ok) begin
        req      = 1'b1;
        req_addr = REDIRECT_PC;
      end else if (!redir && (state_q == FS_RUN) && (credit_need < 3'd2)) begin
        req = 1'b1;
      end
    end
    fetch_pc_d    = req ? (req_addr + 32'd4) : fetch_pc_q;
    inflight_d    = req;
    inflight_pc_d = req_addr;
    push_entry    = '{ir: IMEM_RDATA, pc: inflight_pc_q};
    state_d = state_q;
    if (state_q == FS_BOOT) begin
      state_d = FS_RUN;
    end
    if (redir_ok) begin
      state_d = FS_RUN;
    end else if (redir_bad) begin
      state_d = FS_FAULT;
    end
  end

  // Output view: head of the buffer, zeroed whenever nothing valid is shown.
  always_comb begin
    IMEM_REQ   = req;
    IMEM_ADDR  = req_addr;
    IF_VALID   = if_valid;
    IF_FAULT   = RST_N && (state_q == FS_FAULT);
    if_pc      = if_valid ? fifo_head.pc : 32'd0;
    IF_PC      = if_pc;
    IF_IR      = if_valid ? fifo_head.ir : 32'd0;
    IF_NEXT_PC = if_pc + 32'd4;
  end

  // Control registers: FSM, fetch PC and outstanding-request flag.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= FS_BOOT;
      fetch_pc_q <= RESET_VEC;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // Address of the outstanding request, paired with its returning word.
  always_ff @(posedge CLK) begin
    inflight_pc_q <= inflight_pc_d;
  end

`ifdef OTTER_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Count delivered instructions and cycles where decode holds a valid word.
  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, pop};
    perf_stall_d = perf_stall_q + {31'd0, (if_valid && STALL)};
  end

  // Counter registers, wrapping naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      perf_fetch_q <= 32'd0;
      perf_stall_q <= 32'd0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign PERF_FETCH_CNT = perf_fetch_q;
  assign PERF_STALL_CNT = perf_stall_q;
`else
  assign PERF_FETCH_CNT = 32'd0;
  assign PERF_STALL_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Bench for otter_fetch_unit: directed table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_otter_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
`ifdef OTTER_FETCH_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic        CLK;
  logic        RST_N;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic [31:0] IF_NEXT_PC;
  logic        IF_FAULT;
  logic [31:0] PERF_FETCH_CNT;
  logic [31:0] PERF_STALL_CNT;

  otter_fetch_unit #(.RESET_VEC(RV)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .STALL          (STALL),
    .REDIRECT       (REDIRECT),
    .REDIRECT_PC    (REDIRECT_PC),
    .IMEM_REQ       (IMEM_REQ),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_RDATA     (IMEM_RDATA),
    .IF_VALID       (IF_VALID),
    .IF_IR          (IF_IR),
    .IF_PC          (IF_PC),
    .IF_NEXT_PC     (IF_NEXT_PC),
    .IF_FAULT       (IF_FAULT),
    .PERF_FETCH_CNT (PERF_FETCH_CNT),
    .PERF_STALL_CNT (PERF_STALL_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] instr(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory answers exactly one cycle after a request; junk otherwise.
  always @(posedge CLK) begin
    IMEM_RDATA <= IMEM_REQ ? instr(IMEM_ADDR) : 32'hBAD0_BAD0;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered PCs in order, one optional outstanding request.
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;
  int           m_mode;
  logic [31:0]  m_q[$];
  bit           m_infl;
  logic [31:0]  m_infl_pc;
  logic [31:0]  m_next;
  int unsigned  m_fetch;
  int unsigned  m_stall;

  bit          e_rd, e_rd_ok, e_valid, e_pop, e_req;
  logic [31:0] e_addr;

  task automatic model_reset();
    m_mode  = M_BOOT;
    m_q.delete();
    m_infl  = 1'b0;
    m_infl_pc = 32'd0;
    m_next  = RV;
    m_fetch = 0;
    m_stall = 0;
  endtask

  // Wait to mid-cycle, predict this cycle's outputs and compare.
  task automatic sample();
    @(negedge CLK);
    e_rd    = RST_N && REDIRECT && (m_mode != M_BOOT);
    e_rd_ok = e_rd && (REDIRECT_PC[1:0] == 2'b00);
    e_valid = RST_N && (m_q.size() > 0) && (m_mode != M_FAULT);
    e_pop   = e_valid && !STALL && !e_rd;
    e_req   = 1'b0;
    e_addr  = m_next;
    if (e_rd_ok) begin
      e_req  = 1'b1;
      e_addr = REDIRECT_PC;
    end else if (RST_N && !e_rd && (m_mode == M_RUN) &&
                 ((m_q.size() + int'(m_infl) - int'(e_pop)) < 2)) begin
      e_req = 1'b1;
    end
    chk1("imem_req", IMEM_REQ, e_req);
    if (e_req) chk("imem_addr", IMEM_ADDR, e_addr);
    chk1("if_valid", IF_VALID, e_valid);
    chk1("if_fault", IF_FAULT, RST_N && (m_mode == M_FAULT));
    if (e_valid) begin
      chk("if_pc", IF_PC, m_q[0]);
      chk("if_ir", IF_IR, instr(m_q[0]));
      chk("if_next_pc", IF_NEXT_PC, m_q[0] + 32'd4);
    end
    chk("perf_fetch", PERF_FETCH_CNT, PERF_EN ? m_fetch : 32'd0);
    chk("perf_stall", PERF_STALL_CNT, PERF_EN ? m_stall : 32'd0);
  endtask

  // Cross the clock edge and apply the cycle's effects to the model.
  task automatic advance();
    @(posedge CLK);
    if (!RST_N) begin
      model_reset();
    end else begin
      if (e_valid && STALL) m_stall++;
      if (e_pop) m_fetch++;
      if (e_rd) begin
        m_q.delete();
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
      end
      m_infl    = e_req;
      m_infl_pc = e_addr;
      if (e_req) m_next = e_addr + 32'd4;
      if (m_mode == M_BOOT) m_mode = M_RUN;
      if (e_rd_ok) m_mode = M_RUN;
      else if (e_rd) m_mode = M_FAULT;
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] p);
    RST_N = r;
    STALL = s;
    REDIRECT = d;
    REDIRECT_PC = p;
  endtask

  task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] p);
    drive(r, s, d, p);
    sample();
    advance();
  endtask

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        x_req;
    logic [31:0] x_addr;
    logic        x_valid;
    logic [31:0] x_pc;
    logic        x_fault;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] p,
                              input logic q, input logic [31:0] a, input logic v,
                              input logic [31:0] pc, input logic f);
    vec_t t;
    t.rst_n = r; t.stall = s; t.redir = d; t.rpc = p;
    t.x_req = q; t.x_addr = a; t.x_valid = v; t.x_pc = pc; t.x_fault = f;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int   pops;
    int   stl;

    // Reset, boot, in-order stream from RESET_VEC, misaligned then aligned redirect.
    tbl[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0,   1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0,   1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0,   1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4,   1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h8,   1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0);
    tbl[8]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0,   1'b1);
    tbl[11] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0,   1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200, 1'b0);

    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    model_reset();

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      sample();
      chk1("tbl_req", IMEM_REQ, tbl[i].x_req);
      if (tbl[i].x_req) chk("tbl_addr", IMEM_ADDR, tbl[i].x_addr);
      chk1("tbl_valid", IF_VALID, tbl[i].x_valid);
      if (tbl[i].x_valid) begin
        chk("tbl_pc", IF_PC, tbl[i].x_pc);
        chk("tbl_ir", IF_IR, instr(tbl[i].x_pc));
      end
      if (!tbl[i].rst_n) begin
        chk("rst_if_pc", IF_PC, 32'h0);
        chk("rst_if_ir", IF_IR, 32'h0);
        chk("rst_if_next_pc", IF_NEXT_PC, 32'h4);
      end
      chk1("tbl_fault", IF_FAULT, tbl[i].x_fault);
      advance();
    end

    // Stall for five cycles with IF_PC = 8, then release.
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !(m_q.size() > 0 && m_q[0] == 32'h8); i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      sample();
      chk("stall_if_pc", IF_PC, 32'h8);
      chk1("stall_no_req", IMEM_REQ, 1'b0);
      if (i > 0) chk("stall_occ", {30'd0, dut.fifo_occ}, 32'd2);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      sample();
      chk("release_pc", IF_PC, 32'h8 + 32'(4 * i));
      advance();
    end

    // Fill the buffer, then redirect to 0x100 while STALL is still high.
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h100);
    sample();
    chk("redir_full_occ", {30'd0, dut.fifo_occ}, 32'd2);
    chk1("redir_req", IMEM_REQ, 1'b1);
    chk("redir_addr", IMEM_ADDR, 32'h100);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk1("redir_drop_valid", IF_VALID, 1'b0);
    advance();
    sample();
    chk1("redir_valid", IF_VALID, 1'b1);
    chk("redir_pc", IF_PC, 32'h100);
    advance();

    // Fetch address wraps from 0xFFFF_FFFC to 0.
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    advance();
    sample();
    chk("wrap_next_pc", IF_NEXT_PC, 32'h0);
    advance();

    // Reset mid-stream with one buffered word; refetch from RESET_VEC.
    for (int i = 0; i < 20 && m_q.size() != 1; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("midrst_occ_model", 32'(m_q.size()), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    sample();
    chk1("midrst_req", IMEM_REQ, 1'b0);
    advance();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk1("midrst_valid_next", IF_VALID, 1'b0);
    chk1("midrst_boot_req", IMEM_REQ, 1'b0);
    advance();
    sample();
    chk1("midrst_refetch_req", IMEM_REQ, 1'b1);
    chk("midrst_refetch_addr", IMEM_ADDR, RV);
    advance();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("midrst_first_pc", IF_PC, RV);
    advance();

    // Exactly 10 pops and 3 stall cycles after a fresh reset.
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    pops = 0;
    stl  = 0;
    for (int i = 0; i < 100 && pops < 10; i++) begin
      drive(1'b1, (m_q.size() > 0) && (stl < 3) && (pops >= 4), 1'b0, 32'h0);
      sample();
      if (e_valid && STALL) stl++;
      else if (e_pop) pops++;
      advance();
    end
    chk("perf_pop_budget", 32'(pops), 32'd10);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    sample();
    chk("perf_fetch_10", PERF_FETCH_CNT, PERF_EN ? 32'd10 : 32'd0);
    chk("perf_stall_3", PERF_STALL_CNT, PERF_EN ? 32'd3 : 32'd0);
    advance();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      logic        r, s, d;
      logic [31:0] p;
      int unsigned sel;
      r   = ($urandom_range(0, 199) != 0);
      s   = ($urandom_range(0, 99) < 30);
      d   = ($urandom_range(0, 99) < 6);
      sel = $urandom_range(0, 3);
      case (sel)
        0: p = $urandom & 32'hFFFF_FFFC;
        1: p = 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
        2: p = ($urandom & 32'hFFFF_FFFC) | $urandom_range(1, 3);
        default: p = $urandom_range(0, 255) << 2;
      endcase
      cyc(r, s, d, p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
